mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU. EX issues an operation with `start`.
- The unit asserts `busy` so the hazard logic can stall any later HI/LO consumer.
- Supersedes the fixed single-cycle ALU path with configurable width, throughput (bits per cycle), cancel and signed/unsigned modes.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_step.sv | 58 +++++
 rtl/mdu_iter.sv | 207 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and helpers for the iterative multiply/divide unit.
// Optional feature macro used by mdu_iter: MDU_EARLY_TERM_EN (early multiply exit).
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Width of the iteration counter for n iterations (never narrower than one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration retiring BPC bits.
// Multiply (mode_div_i=0): shift-add, acc += sh when the current multiplier bit is set,
//   then sh shifts left and the multiplier mp shifts right.
// Divide (mode_div_i=1): restoring division on acc = {remainder, dividend/quotient},
//   divisor in sh[WIDTH-1:0]; quotient bits enter at acc[0].
module mdu_step
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic                 mode_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   sh_i,
    input  logic [WIDTH-1:0]     mp_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   sh_o,
    output logic [WIDTH-1:0]     mp_o
);

    logic [2*WIDTH-1:0] acc_v;
    logic [2*WIDTH-1:0] sh_v;
    logic [WIDTH-1:0]   mp_v;
    logic [WIDTH:0]     rem_v;
    logic [WIDTH:0]     diff_v;

    // Unrolled BPC-bit iteration of either shift-add multiply or restoring divide.
    always_comb begin
        acc_v  = acc_i;
        sh_v   = sh_i;
        mp_v   = mp_i;
        rem_v  = '0;
        diff_v = '0;
        for (int k = 0; k < BPC; k++) begin
            if (mode_div_i) begin
                // Partial remainder is always below the divisor, so WIDTH+1 bits suffice.
                rem_v  = {acc_v[2*WIDTH-1:WIDTH], acc_v[WIDTH-1]};
                diff_v = rem_v - {1'b0, sh_v[WIDTH-1:0]};
                if (!diff_v[WIDTH]) begin
                    acc_v = {diff_v[WIDTH-1:0], acc_v[WIDTH-2:0], 1'b1};
                end else begin
                    acc_v = {rem_v[WIDTH-1:0], acc_v[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mp_v[0]) begin
                    acc_v = acc_v + sh_v;
                end else begin
                    acc_v = acc_v;
                end
                sh_v = sh_v << 1;
                mp_v = mp_v >> 1;
            end
        end
        acc_o = acc_v;
        sh_o  = sh_v;
        mp_o  = mp_v;
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
// Holds the FSM (IDLE/RUN/FIX/DONE), operand magnitudes, sign fix and flush handling;
// mdu_step performs the per-cycle arithmetic. BPC must divide WIDTH (1, 2 or 4).
// Optional macro MDU_EARLY_TERM_EN: multiply leaves RUN once no multiplier bits remain.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d;
    logic [WIDTH-1:0]     mp_q, mp_d, hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic                 divz_q, divz_d, dbz_q, dbz_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic [2*WIDTH-1:0]   step_acc_s, step_sh_s, prod_fix_s;
    logic [WIDTH-1:0]     step_mp_s, a_mag_s, b_mag_s, quo_fix_s, rem_fix_s;
    logic                 a_neg_s, b_neg_s, accept_s, is_arith_s, is_div_op_s, early_s;

    mdu_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
        .mode_div_i (is_div_q),
        .acc_i      (acc_q),
        .sh_i       (sh_q),
        .mp_i       (mp_q),
        .acc_o      (step_acc_s),
        .sh_o       (step_sh_s),
        .mp_o       (step_mp_s)
    );

`ifdef MDU_EARLY_TERM_EN
    assign early_s = !is_div_q && (step_mp_s == '0);
`else
    assign early_s = 1'b0;
`endif

    // Operand decode, magnitudes and sign-corrected results.
    always_comb begin
        is_arith_s  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
        accept_s    = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                      (is_arith_s || (op == OP_MTHI) || (op == OP_MTLO));
        a_neg_s     = ((op == OP_MULT) || (op == OP_DIV)) && a[WIDTH-1];
        b_neg_s     = ((op == OP_MULT) || (op == OP_DIV)) && b[WIDTH-1];
        a_mag_s     = a_neg_s ? (~a + 1'b1) : a;
        b_mag_s     = b_neg_s ? (~b + 1'b1) : b;
        prod_fix_s  = neg_q  ? (~acc_q + 1'b1) : acc_q;
        quo_fix_s   = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix_s   = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        mp_d     = mp_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    dbz_d = 1'b0;
                    if (is_arith_s) begin
                        state_d  = ST_RUN;
                        cnt_d    = '0;
                        is_div_d = is_div_op_s;
                        neg_d    = a_neg_s ^ b_neg_s;
                        rneg_d   = a_neg_s;
                        divz_d   = is_div_op_s && (b == '0);
                        if (is_div_op_s) begin
                            // A zero divisor keeps the raw dividend so HI can return it untouched.
                            acc_d = {{WIDTH{1'b0}}, ((b == '0) ? a : a_mag_s)};
                            sh_d  = {{WIDTH{1'b0}}, b_mag_s};
                            mp_d  = '0;
                        end else begin
                            acc_d = '0;
                            sh_d  = {{WIDTH{1'b0}}, a_mag_s};
                            mp_d  = b_mag_s;
                        end
                    end else if (op == OP_MTHI) begin
                        state_d = ST_IDLE;
                        hi_d    = a;
                    end else begin
                        state_d = ST_IDLE;
                        lo_d    = a;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (divz_q) begin
                    // Zero divisor: no iteration, one RUN cycle then straight to FIX.
                    state_d = ST_FIX;
                end else begin
                    acc_d = step_acc_s;
                    sh_d  = step_sh_s;
                    mp_d  = step_mp_s;
                    if ((cnt_q == CNT_LAST) || early_s) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    dbz_d   = divz_q;
                    if (!is_div_q) begin
                        hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix_s[WIDTH-1:0];
                    end else if (divz_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix_s;
                        lo_d = quo_fix_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            mp_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            mp_q     <= mp_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter (BPC=1 instance plus a BPC=4 instance).
module tb_mdu_iter;
    import mdu_pkg::*;

`ifdef MDU_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        bit          mul;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, start4 = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, done, dbz, busy4, done4, dbz4;
    logic [31:0] hi, lo, hi4, lo4;

    mdu_iter #(.WIDTH(32), .BPC(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo));

    mdu_iter #(.WIDTH(32), .BPC(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model using native 64-bit arithmetic; n is the iteration count.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input int n);
        exp_t   e;
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0; e.lat = n + 1; e.mul = (o < 3'd2);
        case (o)
            3'd0: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin u = {32'd0, x} * {32'd0, y}; e.hi = u[63:32]; e.lo = u[31:0]; end
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1; e.lat = 2;
                end else if (o == 3'd2) begin
                    q = sx / sy; r = sx % sy; e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: begin end
        endcase
        return e;
    endfunction

    task automatic issue(input bit four, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y;
        start = !four; start4 = four;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts negedges after the start edge.
    task automatic wait_done(input bit four, input int limit, output int lat, output int busy_bad);
        lat = 0; busy_bad = 0;
        while (((four ? done4 : done) !== 1'b1) && (lat < limit)) begin
            if ((four ? busy4 : busy) !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, dbz} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, dbz}); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        n_cmp++; if ({busy4, done4, dbz4, hi4, lo4} !== 67'd0) begin n_err++; $display("FAIL reset_dut4: got %h expected 0", {busy4, done4, dbz4, hi4, lo4}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Table of multiply/divide cases; the first three use fixed reference results.
    task automatic test_arith();
        logic [2:0] o; logic [31:0] x, y; exp_t e; int lat, bb; bit lat_ok;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin o = OP_MULT;  x = 32'hFFFF_FFFD; y = 32'd7; end
                1: begin o = OP_DIV;   x = 32'hFFFF_FFF9; y = 32'd2; end
                2: begin o = OP_DIV;   x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                3: begin o = OP_MULTU; x = $urandom; y = $urandom; end
                4: begin o = OP_MULT;  x = $urandom; y = $urandom; end
                5: begin o = OP_DIV;   x = $urandom; y = $urandom_range(1, 5000); end
                6: begin o = OP_DIVU;  x = $urandom; y = $urandom; end
                7: begin o = OP_DIV;   x = 32'hFFFF_FC18; y = 32'hFFFF_FFF9; end
                default: begin o = OP_DIVU; x = $urandom; y = 32'd1; end
            endcase
            e = model(o, x, y, 32);
            if (i == 0) begin e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB; end
            if (i == 1) begin e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFD; end
            if (i == 2) begin e.hi = 32'h0000_0000; e.lo = 32'h8000_0000; end
            sb_q.push_back(e);
            @(negedge clk);
            issue(1'b0, o, x, y);
            wait_done(1'b0, 60, lat, bb);
            e = sb_q.pop_front();
            lat_ok = (e.mul && ET) ? ((lat >= 2) && (lat <= e.lat)) : (lat == e.lat);
            n_cmp++; if (hi !== e.hi) begin n_err++; $display("FAIL arith_hi[%0d]: got %h expected %h", i, hi, e.hi); end
            n_cmp++; if (lo !== e.lo) begin n_err++; $display("FAIL arith_lo[%0d]: got %h expected %h", i, lo, e.lo); end
            n_cmp++; if (dbz !== e.dbz) begin n_err++; $display("FAIL arith_dbz[%0d]: got %b expected %b", i, dbz, e.dbz); end
            n_cmp++; if (!lat_ok) begin n_err++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if ((bb != 0) || (busy !== 1'b0)) begin n_err++; $display("FAIL arith_busy[%0d]: got %0d low-busy cycles, busy=%b at done, expected 0/0", i, bb, busy); end
        end
    endtask

    task automatic test_div_zero();
        exp_t e; int lat, bb;
        e.hi = 32'h0000_0064; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 2; e.mul = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        issue(1'b0, OP_DIVU, 32'd100, 32'd0);
        wait_done(1'b0, 60, lat, bb);
        e = sb_q.pop_front();
        n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL dz_latency: got %0d expected %0d", lat, e.lat); end
        n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++; $display("FAIL dz_hilo: got %h expected %h", {hi, lo}, {e.hi, e.lo}); end
        n_cmp++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", dbz); end
        repeat (3) @(negedge clk);
        n_cmp++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dz_sticky: got %b expected 1", dbz); end
        sb_q.push_back(model(OP_MULTU, 32'd3, 32'd4, 32));
        issue(1'b0, OP_MULTU, 32'd3, 32'd4);
        n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b expected 0", dbz); end
        wait_done(1'b0, 60, lat, bb);
        e = sb_q.pop_front();
        n_cmp++; if ({hi, lo, dbz} !== {e.hi, e.lo, e.dbz}) begin n_err++; $display("FAIL dz_next_result: got %h expected %h", {hi, lo, dbz}, {e.hi, e.lo, e.dbz}); end
    endtask

    task automatic test_flush();
        int ign_at, flush_at, done_cnt;
        ign_at   = ET ? 0 : 5;
        flush_at = ET ? 1 : 10;
        @(negedge clk);
        issue(1'b0, OP_MTHI, 32'h0000_1234, 32'd0);
        n_cmp++; if ({hi, busy, done} !== {32'h0000_1234, 2'b00}) begin n_err++; $display("FAIL mthi: got %h expected %h", {hi, busy, done}, {32'h0000_1234, 2'b00}); end
        issue(1'b0, OP_MTLO, 32'h0000_5678, 32'd0);
        n_cmp++; if (lo !== 32'h0000_5678) begin n_err++; $display("FAIL mtlo: got %h expected 00005678", lo); end
        flush = 1'b1;
        issue(1'b0, OP_MTHI, 32'hDEAD_0001, 32'd0);
        issue(1'b0, OP_MULTU, 32'd5, 32'd6);
        flush = 1'b0;
        n_cmp++; if ({hi, busy} !== {32'h0000_1234, 1'b0}) begin n_err++; $display("FAIL start_with_flush: got %h expected %h", {hi, busy}, {32'h0000_1234, 1'b0}); end
        issue(1'b0, OP_MULTU, 32'd5, 32'd6);
        for (int k = 0; k < flush_at; k++) begin
            if (k == ign_at) begin start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF; end
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++; if ({busy, hi} !== {1'b1, 32'h0000_1234}) begin n_err++; $display("FAIL start_while_busy: got %h expected %h", {busy, hi}, {1'b1, 32'h0000_1234}); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL flush_busy: got %b expected 00", {busy, done}); end
        done_cnt = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) done_cnt++; end
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL flush_no_done: got %0d expected 0", done_cnt); end
        n_cmp++; if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678}) begin n_err++; $display("FAIL flush_hilo: got %h expected %h", {hi, lo}, {32'h0000_1234, 32'h0000_5678}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({busy, done, dbz, hi, lo} !== 67'd0) begin n_err++; $display("FAIL reset_mid_run: got %h expected 0", {busy, done, dbz, hi, lo}); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bpc4();
        logic [31:0] x, y; logic [2:0] o; exp_t e; int lat, bb;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                o = OP_MULTU; x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF;
                e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0; e.lat = 9; e.mul = 1'b1;
            end else begin
                o = OP_DIV; x = $urandom; y = $urandom_range(1, 300);
                e = model(o, x, y, 8);
            end
            sb_q.push_back(e);
            @(negedge clk);
            issue(1'b1, o, x, y);
            wait_done(1'b1, 60, lat, bb);
            e = sb_q.pop_front();
            n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL bpc4_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
            n_cmp++; if ({hi4, lo4} !== {e.hi, e.lo}) begin n_err++; $display("FAIL bpc4_hilo[%0d]: got %h expected %h", i, {hi4, lo4}, {e.hi, e.lo}); end
        end
    endtask

    task automatic test_early_term();
        exp_t e; int lat, bb; bit lat_ok;
        e.hi = 32'd0; e.lo = 32'h1234_5678; e.dbz = 1'b0; e.lat = 33; e.mul = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        issue(1'b0, OP_MULTU, 32'h1234_5678, 32'd1);
        wait_done(1'b0, 60, lat, bb);
        e = sb_q.pop_front();
        lat_ok = ET ? ((lat >= 2) && (lat <= 3)) : (lat == e.lat);
        n_cmp++; if (!lat_ok) begin n_err++; $display("FAIL early_latency: got %0d expected %0d", lat, ET ? 3 : e.lat); end
        n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++; $display("FAIL early_hilo: got %h expected %h", {hi, lo}, {e.hi, e.lo}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2; exp_t e; int lat, bb;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom_range(1, 70000);
        sb_q.push_back(model(OP_MULT, x1, y1, 32));
        sb_q.push_back(model(OP_DIVU, x2, y2, 32));
        @(negedge clk);
        issue(1'b0, OP_MULT, x1, y1);
        wait_done(1'b0, 60, lat, bb);
        e = sb_q.pop_front();
        n_cmp++; if ({hi, lo} !== {e.hi, e.lo}) begin n_err++; $display("FAIL b2b_first: got %h expected %h", {hi, lo}, {e.hi, e.lo}); end
        issue(1'b0, OP_DIVU, x2, y2);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_accept_in_done: got %b expected 10", {busy, done}); end
        wait_done(1'b0, 60, lat, bb);
        e = sb_q.pop_front();
        n_cmp++; if ({hi, lo, lat} !== {e.hi, e.lo, e.lat}) begin n_err++; $display("FAIL b2b_second: got %h/%0d expected %h/%0d", {hi, lo}, lat, {e.hi, e.lo}, e.lat); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_bpc4();
        test_early_term();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
